// File: rtl/gate_vector_checker.sv
// Stimulus/response checker for the logic_gates block: sweeps {a,b} through 00,10,01,11,
// compares the seven gate outputs against the truth table and records the first failure.
module gate_vector_checker #(
    parameter int HOLD_CYCLES = 2,
    parameter int PASSES      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic [6:0] gate_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [1:0] fail_vec,
    output logic [6:0] fail_mask
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] PASS_LAST = 8'(PASSES - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] pass_cnt_q, pass_cnt_d;
    logic       a_q, a_d, b_q, b_d;
    logic [7:0] err_q, err_d;
    logic [1:0] fail_vec_q, fail_vec_d;
    logic [6:0] fail_mask_q, fail_mask_d;
    logic       pass_q, pass_d;
    logic [6:0] expected;
    logic       mismatch;

    // Packed {and, or, not_a, nand, nor, xor, xnor}; index n drives a=n[0], b=n[1].
    always_comb begin
        unique case (idx_q)
            2'd0:    expected = 7'h1D;
            2'd1:    expected = 7'h2A;
            2'd2:    expected = 7'h3A;
            default: expected = 7'h61;
        endcase
    end

    assign mismatch = (gate_out != expected);

    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        pass_cnt_d  = pass_cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        err_d       = err_q;
        fail_vec_d  = fail_vec_q;
        fail_mask_d = fail_mask_q;
        pass_d      = pass_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = DRIVE;
                    idx_d       = 2'd0;
                    hold_d      = 8'd0;
                    pass_cnt_d  = 8'd0;
                    a_d         = 1'b0;
                    b_d         = 1'b0;
                    err_d       = 8'd0;
                    fail_vec_d  = 2'd0;
                    fail_mask_d = 7'd0;
                    pass_d      = 1'b0;
                end
            end
            DRIVE: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = SAMPLE;
                    hold_d  = 8'd0;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    // A zero count means no earlier failure in this run.
                    if (err_q == 8'd0) begin
                        fail_vec_d  = {a_q, b_q};
                        fail_mask_d = gate_out ^ expected;
                    end
                end
                if (idx_q != 2'd3) begin
                    state_d = DRIVE;
                    idx_d   = idx_q + 2'd1;
                    a_d     = idx_d[0];
                    b_d     = idx_d[1];
                end else if (pass_cnt_q < PASS_LAST) begin
                    state_d    = DRIVE;
                    idx_d      = 2'd0;
                    pass_cnt_d = pass_cnt_q + 8'd1;
                    a_d        = 1'b0;
                    b_d        = 1'b0;
                end else begin
                    state_d = DONE;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    pass_d  = (err_d == 8'd0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            hold_q      <= 8'd0;
            pass_cnt_q  <= 8'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            err_q       <= 8'd0;
            fail_vec_q  <= 2'd0;
            fail_mask_q <= 7'd0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            pass_cnt_q  <= pass_cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            err_q       <= err_d;
            fail_vec_q  <= fail_vec_d;
            fail_mask_q <= fail_mask_d;
            pass_q      <= pass_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_vec_q;
    assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker: three instances (defaults, PASSES=100, HOLD_CYCLES=1)
// each wrapped around a behavioural logic_gates model with selectable faults.
module tb_gate_vector_checker;

    logic       clk;
    logic       rst_n;
    logic       start_v     [3];
    logic       a_v         [3];
    logic       b_v         [3];
    logic [6:0] gout_v      [3];
    logic       busy_v      [3];
    logic       done_v      [3];
    logic       pass_v      [3];
    logic [7:0] err_v       [3];
    logic [1:0] fail_vec_v  [3];
    logic [6:0] fail_mask_v [3];
    int         mode_v      [3];

    int tests = 0;
    int fails = 0;

    int done_n, done_cnt, busy_cnt, ab_bad;
    logic pass_at_done;

    gate_vector_checker u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
        .gate_out(gout_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .err_count(err_v[0]), .fail_vec(fail_vec_v[0]), .fail_mask(fail_mask_v[0])
    );

    gate_vector_checker #(.HOLD_CYCLES(2), .PASSES(100)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
        .gate_out(gout_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .err_count(err_v[1]), .fail_vec(fail_vec_v[1]), .fail_mask(fail_mask_v[1])
    );

    gate_vector_checker #(.HOLD_CYCLES(1), .PASSES(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
        .gate_out(gout_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .err_count(err_v[2]), .fail_vec(fail_vec_v[2]), .fail_mask(fail_mask_v[2])
    );

    // Mode 0: golden gates; 1: xor output stuck at 0; 2: every output inverted.
    function automatic logic [6:0] gates(input logic ia, input logic ib, input int mode);
        logic [6:0] g;
        g = {ia & ib, ia | ib, ~ia, ~(ia & ib), ~(ia | ib), ia ^ ib, ~(ia ^ ib)};
        if (mode == 1) g[1] = 1'b0;
        if (mode == 2) g = ~g;
        return g;
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) gout_v[i] = gates(a_v[i], b_v[i], mode_v[i]);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses start on instance w, then watches it for a bounded number of cycles.
    // Cycle n is the cycle after edge k+n, where k is the edge that accepted start.
    task automatic run(input int w, input int hold, input int passes,
                       input bit repulse, input int abort_at);
        int n_total;
        int limit;
        int idx;
        n_total      = 4 * passes * (hold + 1);
        limit        = n_total + 20;
        done_n       = -1;
        done_cnt     = 0;
        busy_cnt     = 0;
        ab_bad       = 0;
        pass_at_done = 1'bx;
        start_v[w] = 1'b1;
        @(posedge clk); #1;
        start_v[w] = 1'b0;
        for (int n = 0; n < limit; n++) begin
            if (busy_v[w]) busy_cnt++;
            if (done_v[w]) begin
                done_cnt++;
                if (done_n < 0) begin
                    done_n       = n + 1;
                    pass_at_done = pass_v[w];
                end
            end
            if (n < n_total) begin
                idx = (n / (hold + 1)) % 4;
                if (a_v[w] !== idx[0] || b_v[w] !== idx[1]) ab_bad++;
            end else if (a_v[w] !== 1'b0 || b_v[w] !== 1'b0) begin
                ab_bad++;
            end
            if (n == abort_at) begin
                check("err before abort", err_v[w], 1);
                rst_n = 1'b0;
                #1;
                check("abort busy", busy_v[w], 0);
                check("abort ab", {a_v[w], b_v[w]}, 0);
                check("abort err_count", err_v[w], 0);
                check("abort fail_vec/mask", {fail_vec_v[w], fail_mask_v[w]}, 0);
                check("abort pass/done", {pass_v[w], done_v[w]}, 0);
                rst_n   = 1'b1;
                n_total = 0;
            end
            start_v[w] = repulse && (n == 3 || n == 12);
            @(posedge clk); #1;
        end
        start_v[w] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            mode_v[i]  = 0;
        end
        mode_v[1] = 2;
        #12;
        check("reset ab/busy/done/pass", {a_v[0], b_v[0], busy_v[0], done_v[0], pass_v[0]}, 0);
        check("reset err_count", err_v[0], 0);
        check("reset fail_vec/mask", {fail_vec_v[0], fail_mask_v[0]}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Golden sweep with defaults.
        run(0, 2, 1, 1'b0, -1);
        check("golden done edge", done_n, 13);
        check("golden done count", done_cnt, 1);
        check("golden busy cycles", busy_cnt, 12);
        check("golden ab sequence", ab_bad, 0);
        check("golden pass at done", pass_at_done, 1);
        check("golden pass held", pass_v[0], 1);
        check("golden err_count", err_v[0], 0);
        check("golden fail_mask", fail_mask_v[0], 0);

        // xor stuck at 0.
        mode_v[0] = 1;
        run(0, 2, 1, 1'b0, -1);
        check("xor0 done edge", done_n, 13);
        check("xor0 err_count", err_v[0], 2);
        check("xor0 fail_vec", fail_vec_v[0], 2'b10);
        check("xor0 fail_mask", fail_mask_v[0], 7'h02);
        check("xor0 pass at done", pass_at_done, 0);
        check("xor0 pass held", pass_v[0], 0);

        // Inverted outputs, 100 passes: 400 mismatches saturate the counter.
        run(1, 2, 100, 1'b0, -1);
        check("sat done edge", done_n, 1201);
        check("sat busy cycles", busy_cnt, 1200);
        check("sat ab sequence", ab_bad, 0);
        check("sat err_count", err_v[1], 255);
        check("sat fail_vec", fail_vec_v[1], 2'b00);
        check("sat fail_mask", fail_mask_v[1], 7'h7F);
        check("sat pass", pass_v[1], 0);

        // Golden rerun with start re-pulsed mid-run and in DONE; clears previous failures.
        mode_v[0] = 0;
        run(0, 2, 1, 1'b1, -1);
        check("repulse done count", done_cnt, 1);
        check("repulse done edge", done_n, 13);
        check("repulse busy cycles", busy_cnt, 12);
        check("repulse ab sequence", ab_bad, 0);
        check("rerun err cleared", err_v[0], 0);
        check("rerun fail cleared", {fail_vec_v[0], fail_mask_v[0]}, 0);
        check("rerun pass", pass_v[0], 1);

        // Reset during the vector 01 DRIVE phase, then a fresh golden run.
        mode_v[0] = 1;
        run(0, 2, 1, 1'b0, 6);
        check("abort no done", done_cnt, 0);
        check("abort ab sequence", ab_bad, 0);
        mode_v[0] = 0;
        run(0, 2, 1, 1'b0, -1);
        check("post-abort done edge", done_n, 13);
        check("post-abort ab sequence", ab_bad, 0);
        check("post-abort pass", pass_v[0], 1);

        // HOLD_CYCLES = 1.
        run(2, 1, 1, 1'b0, -1);
        check("hold1 done edge", done_n, 9);
        check("hold1 busy cycles", busy_cnt, 8);
        check("hold1 ab sequence", ab_bad, 0);
        check("hold1 pass", pass_v[2], 1);
        check("hold1 err_count", err_v[2], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gate_vector_checker.md
# gate_vector_checker

Self-checking stimulus/response stage for the `logic_gates` block: it drives the `a`/`b` inputs through the exhaustive sweep 00, 10, 01, 11 and consumes the seven gate outputs. Each captured output is compared against the expected truth-table value. The stage counts mismatches and records the first failure. It sits directly upstream of and around `logic_gates` on the bring-up path, which lets the gate block be checked in hardware without the simulation test bench.

## Interface
- `HOLD_CYCLES`, default 2: cycles each vector is held before sampling; legal range 1..255.
- `PASSES`, default 1: number of full 4-vector sweeps per run; legal range 1..255.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `a`  out  1  stimulus to `logic_gates` input a; registered.
- `b`  out  1  stimulus to `logic_gates` input b; registered.
- `gate_out`  in  7  DUT outputs packed {and_, or_, not_a, nand_, nor_, xor_, xnor_}, bit 6 down to bit 0.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass`  out  1  high when the last run had `err_count == 0`; held until the next `start`.
- `err_count`  out  8  number of mismatching samples; saturates at 255.
- `fail_vec`  out  2  {a,b} of the first failing sample.
- `fail_mask`  out  7  `gate_out ^ expected` at the first failing sample.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE -> DRIVE on `start`. Entering DRIVE:
  - clear `err_count`, `fail_vec`, `fail_mask`, `pass`;
  - set vector index = 0, pass counter = 0, hold counter = 0.
- DRIVE:
  - `a`/`b` present the vector for the current index. Index order: 0 -> {a,b}=00, 1 -> 10, 2 -> 01, 3 -> 11.
  - The hold counter increments each cycle; after HOLD_CYCLES cycles, go to SAMPLE.
- SAMPLE, one cycle:
  - compare `gate_out` against expected. Expected values: 00 -> 7'h1D, 10 -> 7'h2A, 01 -> 7'h3A, 11 -> 7'h61.
  - On mismatch, `err_count` increments, saturating at 255.
  - On the first mismatch of the run only, latch `fail_vec` and `fail_mask`.
- Leaving SAMPLE:
  - if index < 3: index+1, go to DRIVE;
  - else if pass counter < PASSES-1: index = 0, pass counter +1, go to DRIVE;
  - else go to DONE.
- DONE, one cycle:
  - `done`=1, `busy`=0;
  - `pass` = (final `err_count == 0`);
  - then go to IDLE.
- In IDLE and DONE, `a`=`b`=0.
- `start` is ignored in DRIVE, SAMPLE and DONE; it is not queued.
- `err_count`, `fail_*` and `pass` hold their values in IDLE until the next accepted `start`.

## Timing
- Reset values: state IDLE, `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0, `fail_mask`=0.
- Reset asserted mid-run: all outputs return to their reset values immediately (asynchronous). There is no `done` pulse for the aborted run.
- Start accepted at edge k:
  - `busy`=1 and vector 00 on `a`/`b` from edge k+1;
  - each vector occupies HOLD_CYCLES+1 cycles (DRIVE plus SAMPLE);
  - `busy` is high for 4·PASSES·(HOLD_CYCLES+1) cycles;
  - `done` pulses on the following cycle.
  - Defaults: `busy` for 12 cycles, `done` at edge k+13.
- `a`/`b` change only on the SAMPLE -> DRIVE, IDLE -> DRIVE and SAMPLE -> DONE edges.
- `gate_out` is sampled combinationally during SAMPLE and is therefore at least HOLD_CYCLES cycles stable after the vector changes.
- The `err_count` update and the first-fail latch take effect on the edge that ends SAMPLE.
- `done` coincides with the final `pass` value.

## Test plan
- Golden `logic_gates` connected, defaults, `start` pulsed once -> a/b sequence 00,10,01,11 with 3 cycles per vector; `done` at start+13; `pass`=1, `err_count`=0, `fail_mask`=0.
- `gate_out[1]` (xor_) forced to 0 -> mismatches at 10 and 01; `err_count`=2, `fail_vec`=2'b10, `fail_mask`=7'h02, `pass`=0.
- `gate_out` = bitwise inverse of expected, PASSES=100 -> 400 mismatches, `err_count` saturates at 255; `fail_vec`=00, `fail_mask`=7'h7F.
- `start` re-pulsed at cycles 3 and 12 of a run -> ignored: a single `done` and unchanged timing. A second `start` after `done` clears the results and reruns.
- `rst_n` pulled low during the vector 01 DRIVE -> outputs at reset values asynchronously; no `done` pulse; a fresh `start` runs the full sweep.
- HOLD_CYCLES=1 -> 2 cycles per vector; `done` at start+9 with the golden model.
